clkgen_phase_sched: RTL and testbench
=====================================

Name: clkgen_phase_sched

Overview:
- Configuration scheduler for the 32-step non-overlapping clock generator.
- Owns the generator's PHASE_SEL and duty field (SET[19:16]) and changes them only at frame boundaries.
- Masks generated clocks for one guard frame after every change.
- Supports host-requested settings (valid/ready) and an autonomous phase sweep; sits between the control register block and the generator.

Parameters:
- PHASE_DEFAULT, 5'd0, phase loaded at reset.
- DUTY_DEFAULT, 4'd0, duty field loaded at reset.
- FRAME_LEN, 32, cycles per frame; fixed to match the generator's 5-bit counter, not to be overridden.

Ports:
- CLK_IN  in  1  generator input clock; all logic on posedge.
- RESET_N  in  1  synchronous, active-low reset.
- CFG_VALID  in  1  host request valid.
- CFG_READY  out  1  scheduler can accept a request.
- CFG_PHASE  in  5  requested phase.
- CFG_DUTY  in  4  requested duty field.
- SWEEP_EN  in  1  enable autonomous phase sweep.
- SWEEP_STEP  in  5  phase increment per sweep step, modulo 32.
- SWEEP_DWELL  in  8  frames to hold each sweep phase; 0 is treated as 1.
- PHASE_SEL  out  5  to generator PHASE_SEL.
- SET  out  32  to generator SET; [19:16] = duty, all other bits 0.
- CLK_GATE  out  1  1 = downstream must mask generated clocks.
- FRAME_TICK  out  1  high on the boundary cycle (frame count == 0).
- SWEEP_WRAP  out  1  one-cycle pulse when the sweep phase wraps past 31.
- BUSY  out  1  state != RUN.

Behaviour:
- Frame counter: 5-bit down counter fcnt, 31→0 then reload 31. Reset value 31. Boundary cycle = fcnt==0.
- Reset (RESET_N=0 at posedge):
  - PHASE_SEL=PHASE_DEFAULT, duty=DUTY_DEFAULT, fcnt=31.
  - State GUARD, CLK_GATE=1, CFG_READY=0.
  - Staged regs cleared; dwell counter 0; SWEEP_WRAP=0.
- States:
  - RUN:
    - CFG_READY=1, CLK_GATE=0.
    - A handshake (CFG_VALID & CFG_READY) stages {CFG_PHASE, CFG_DUTY} and moves to PEND.
    - Otherwise, if SWEEP_EN, the dwell counter increments on each boundary cycle. When it reaches max(SWEEP_DWELL,1), stage {PHASE_SEL+SWEEP_STEP mod 32, current duty}, clear the dwell counter, and go to PEND.
    - SWEEP_WRAP pulses in the same cycle when that 6-bit sum is ≥32.
  - PEND:
    - CFG_READY=0.
    - On the boundary cycle, load PHASE_SEL/SET from staged values (visible the next cycle), set CLK_GATE=1 (next cycle), and go to GUARD.
  - GUARD:
    - CFG_READY=0, CLK_GATE=1 for exactly one full frame (32 cycles, fcnt 31..0).
    - On the boundary cycle, CLK_GATE deasserts (next cycle) and the state goes to RUN.
- Latency:
  - A request accepted at fcnt=k (k>0) appears on PHASE_SEL k+1 cycles later.
  - Gate is high for 32 cycles after that.
  - A request accepted on a boundary cycle waits for the following boundary (32 cycles). No same-cycle apply.
- Priority:
  - A host handshake in the same cycle as a sweep trigger wins.
  - The sweep trigger is discarded and the dwell counter is cleared.
- Dropping SWEEP_EN clears the dwell counter and does not cancel a step already in PEND.
- While not in RUN: CFG_VALID is ignored (no stage, no error); the host must hold it.
- Reset mid-PEND or mid-GUARD: staged value is lost; reset values apply.
- FRAME_TICK is combinational from fcnt. All other outputs are registered.
- Arithmetic: phase add is 5-bit wrap. Dwell counter is 8-bit, saturates at 255.

Decomposition:
- Shared package clkgen_pkg:
  - FRAME_LEN=32, PHASE_W=5, DUTY_W=4, DUTY_LSB=16.
  - State enum {RUN, PEND, GUARD}.
  - Function to pack duty into the 32-bit SET word.
- One natural sub-module: clkgen_frame_counter (fcnt, boundary flag, FRAME_TICK), reusable to keep other blocks aligned with the generator.

Test Plan:
- Reset with defaults 0/0, then run 40 cycles → CLK_GATE=1 for cycles 1–32 after reset release, 0 from cycle 33; CFG_READY=1 from cycle 33; PHASE_SEL=0, SET=0.
- In RUN at fcnt=10: CFG_PHASE=7, CFG_DUTY=3 → PHASE_SEL=7 and SET=32'h0003_0000 after 11 cycles; CLK_GATE high 32 cycles; BUSY high from cycle after accept until gate release.
- SWEEP_EN=1, STEP=8, DWELL=2, start phase 0 → PHASE_SEL sequence 8,16,24,0; each step 2 frames after return to RUN; SWEEP_WRAP pulses once on the 24→0 step.
- Sweep trigger and CFG_VALID (phase 5) in same cycle → PHASE_SEL=5 applied, no sweep step, dwell restarts from 0.
- CFG_VALID held during GUARD → no acceptance until RUN; accepted on the first RUN cycle.
- RESET_N low for one cycle while in PEND with staged phase 12 → PHASE_SEL returns to PHASE_DEFAULT; 12 is never applied.

Source files
------------

// File: rtl/clkgen_phase_sched_pkg.sv
// Shared constants, state encoding and SET-word packing for the clock
// generator phase scheduler and anything that must stay frame-aligned with it.
package clkgen_pkg;

    localparam int FRAME_LEN = 32;
    localparam int PHASE_W   = 5;
    localparam int DUTY_W    = 4;
    localparam int DUTY_LSB  = 16;
    localparam int DWELL_W   = 8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

    // The duty field is the only live field of the generator SET word.
    function automatic logic [31:0] pack_set(input logic [DUTY_W-1:0] duty);
        logic [31:0] word;
        word = '0;
        word[DUTY_LSB +: DUTY_W] = duty;
        return word;
    endfunction

endpackage

// File: rtl/clkgen_phase_sched_if.sv
// Host/generator-facing signal bundle of the phase scheduler; the scheduler
// takes the slave view, the host/control block the master view.
interface clkgen_phase_sched_if;
    import clkgen_pkg::*;

    logic                 CFG_VALID;
    logic                 CFG_READY;
    logic [PHASE_W-1:0]   CFG_PHASE;
    logic [DUTY_W-1:0]    CFG_DUTY;
    logic                 SWEEP_EN;
    logic [PHASE_W-1:0]   SWEEP_STEP;
    logic [DWELL_W-1:0]   SWEEP_DWELL;
    logic [PHASE_W-1:0]   PHASE_SEL;
    logic [31:0]          SET;
    logic                 CLK_GATE;
    logic                 FRAME_TICK;
    logic                 SWEEP_WRAP;
    logic                 BUSY;

    modport master (
        output CFG_VALID, CFG_PHASE, CFG_DUTY, SWEEP_EN, SWEEP_STEP, SWEEP_DWELL,
        input  CFG_READY, PHASE_SEL, SET, CLK_GATE, FRAME_TICK, SWEEP_WRAP, BUSY
    );

    modport slave (
        input  CFG_VALID, CFG_PHASE, CFG_DUTY, SWEEP_EN, SWEEP_STEP, SWEEP_DWELL,
        output CFG_READY, PHASE_SEL, SET, CLK_GATE, FRAME_TICK, SWEEP_WRAP, BUSY
    );

endinterface

// File: rtl/clkgen_phase_sched_frame_counter.sv
// 5-bit down counter mirroring the generator's frame counter (31 -> 0, reload 31);
// frame_tick marks the boundary cycle where fcnt == 0.
module clkgen_frame_counter
    import clkgen_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    output logic [PHASE_W-1:0] fcnt,
    output logic               frame_tick
);

    logic [PHASE_W-1:0] fcnt_reg;

    // 0 - 1 wraps to 31, which is exactly the reload value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt_reg <= PHASE_W'(FRAME_LEN - 1);
        end else begin
            fcnt_reg <= fcnt_reg - 1'b1;
        end
    end

    assign fcnt       = fcnt_reg;
    assign frame_tick = (fcnt_reg == '0);

endmodule

// File: rtl/clkgen_phase_sched.sv
// Phase/duty scheduler: applies host or sweep settings only on frame
// boundaries and masks the generated clocks for one guard frame afterwards.
module clkgen_phase_sched
    import clkgen_pkg::*;
#(
    parameter logic [PHASE_W-1:0] PHASE_DEFAULT = 5'd0,
    parameter logic [DUTY_W-1:0]  DUTY_DEFAULT  = 4'd0
) (
    input  logic                 CLK_IN,
    input  logic                 RESET_N,
    clkgen_phase_sched_if.slave  bus
);

    localparam logic [1:0] S_RUN   = 2'(ST_RUN);
    localparam logic [1:0] S_PEND  = 2'(ST_PEND);
    localparam logic [1:0] S_GUARD = 2'(ST_GUARD);

    logic [PHASE_W-1:0] fcnt;
    logic               frame_tick;
    logic               boundary;

    logic [1:0]         state_reg,     state_next;
    logic [PHASE_W-1:0] phase_reg,     phase_next;
    logic [DUTY_W-1:0]  duty_reg,      duty_next;
    logic [PHASE_W-1:0] stg_phase_reg, stg_phase_next;
    logic [DUTY_W-1:0]  stg_duty_reg,  stg_duty_next;
    logic [DWELL_W-1:0] dwell_reg,     dwell_next;
    logic               wrap_reg,      wrap_next;
    logic               ready_reg;
    logic               gate_reg;
    logic               busy_reg;

    logic               handshake;
    logic [DWELL_W-1:0] dwell_limit;
    logic [DWELL_W-1:0] dwell_inc;
    logic [PHASE_W:0]   sweep_sum;

    clkgen_frame_counter u_frame_counter (
        .clk        (CLK_IN),
        .rst_n      (RESET_N),
        .fcnt       (fcnt),
        .frame_tick (frame_tick)
    );

    assign boundary = (fcnt == '0);

    assign handshake   = bus.CFG_VALID && ready_reg;
    assign dwell_limit = (bus.SWEEP_DWELL == '0) ? DWELL_W'(1) : bus.SWEEP_DWELL;
    assign dwell_inc   = (dwell_reg == '1) ? dwell_reg : dwell_reg + 1'b1;
    // Carry bit of this sum is the sweep wrap indication.
    assign sweep_sum   = {1'b0, phase_reg} + {1'b0, bus.SWEEP_STEP};

    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        duty_next      = duty_reg;
        stg_phase_next = stg_phase_reg;
        stg_duty_next  = stg_duty_reg;
        dwell_next     = dwell_reg;
        wrap_next      = 1'b0;

        case (state_reg)
            S_RUN: begin
                if (handshake) begin
                    stg_phase_next = bus.CFG_PHASE;
                    stg_duty_next  = bus.CFG_DUTY;
                    dwell_next     = '0;
                    state_next     = S_PEND;
                end else if (bus.SWEEP_EN && boundary) begin
                    if (dwell_inc >= dwell_limit) begin
                        stg_phase_next = sweep_sum[PHASE_W-1:0];
                        stg_duty_next  = duty_reg;
                        dwell_next     = '0;
                        wrap_next      = sweep_sum[PHASE_W];
                        state_next     = S_PEND;
                    end else begin
                        dwell_next = dwell_inc;
                    end
                end
            end
            S_PEND: begin
                if (boundary) begin
                    phase_next = stg_phase_reg;
                    duty_next  = stg_duty_reg;
                    state_next = S_GUARD;
                end
            end
            S_GUARD: begin
                if (boundary) begin
                    state_next = S_RUN;
                end
            end
            default: begin
                state_next = S_GUARD;
            end
        endcase

        // A step already staged survives; only the dwell progress is dropped.
        if (!bus.SWEEP_EN) begin
            dwell_next = '0;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (!RESET_N) begin
            state_reg     <= S_GUARD;
            phase_reg     <= PHASE_DEFAULT;
            duty_reg      <= DUTY_DEFAULT;
            stg_phase_reg <= '0;
            stg_duty_reg  <= '0;
            dwell_reg     <= '0;
            wrap_reg      <= 1'b0;
            ready_reg     <= 1'b0;
            gate_reg      <= 1'b1;
            busy_reg      <= 1'b1;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            duty_reg      <= duty_next;
            stg_phase_reg <= stg_phase_next;
            stg_duty_reg  <= stg_duty_next;
            dwell_reg     <= dwell_next;
            wrap_reg      <= wrap_next;
            ready_reg     <= (state_next == S_RUN);
            gate_reg      <= (state_next == S_GUARD);
            busy_reg      <= (state_next != S_RUN);
        end
    end

    assign bus.CFG_READY  = ready_reg;
    assign bus.PHASE_SEL  = phase_reg;
    assign bus.SET        = pack_set(duty_reg);
    assign bus.CLK_GATE   = gate_reg;
    assign bus.FRAME_TICK = frame_tick;
    assign bus.SWEEP_WRAP = wrap_reg;
    assign bus.BUSY       = busy_reg;

endmodule

// File: tb/tb_clkgen_phase_sched.sv
// Directed bench for clkgen_phase_sched: stimulus pushes expected output
// changes (with cycle numbers) into a queue, a negedge monitor pops and compares.
module tb_clkgen_phase_sched;

    typedef struct packed {
        logic [4:0]  phase;
        logic [31:0] set;
        logic        gate;
        logic        ready;
        logic        busy;
        logic        wrap;
    } snap_t;

    typedef struct {
        int    cyc;
        snap_t s;
    } ev_t;

    logic  clk;
    logic  RESET_N;
    int    cyc;
    int    checks;
    int    failures;
    bit    done;
    bit    reported;
    snap_t cur;
    snap_t prev;
    ev_t   exp_q[$];
    ev_t   e;
    bit    tick_exp;

    clkgen_phase_sched_if bus();

    clkgen_phase_sched dut (
        .CLK_IN  (clk),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle 1 is the first cycle after the last posedge that sampled reset low.
    initial cyc = 0;
    always @(posedge clk) begin
        if (!RESET_N) cyc <= 1;
        else          cyc <= cyc + 1;
    end

    task automatic exp_ev(input int c, input logic [4:0] p, input logic [3:0] d,
                          input logic g, input logic r, input logic w);
        ev_t x;
        x.cyc     = c;
        x.s.phase = p;
        x.s.set   = 32'(d) << 16;
        x.s.gate  = g;
        x.s.ready = r;
        x.s.busy  = ~r;
        x.s.wrap  = w;
        exp_q.push_back(x);
    endtask

    task automatic goto(input int n);
        while (cyc != n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req_at(input int c, input logic [4:0] p, input logic [3:0] d);
        goto(c);
        bus.CFG_VALID = 1'b1;
        bus.CFG_PHASE = p;
        bus.CFG_DUTY  = d;
        @(posedge clk);
        #1;
        bus.CFG_VALID = 1'b0;
    endtask

    // Monitor: one comparison per observed output change, plus FRAME_TICK each cycle.
    initial begin
        checks = 0; failures = 0; reported = 0;
        prev = '0;
    end

    always @(negedge clk) begin
        cur = '{phase: bus.PHASE_SEL, set: bus.SET, gate: bus.CLK_GATE,
                ready: bus.CFG_READY, busy: bus.BUSY, wrap: bus.SWEEP_WRAP};
        if (RESET_N === 1'b1) begin
            tick_exp = ((cyc % 32) == 0);
            checks++;
            if (bus.FRAME_TICK !== tick_exp) begin
                failures++;
                $display("FAIL frame_tick cyc=%0d got=%b exp=%b", cyc, bus.FRAME_TICK, tick_exp);
            end
            if (cyc == 1 || cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event cyc=%0d got phase=%0d set=%h gate=%b ready=%b busy=%b wrap=%b",
                             cyc, cur.phase, cur.set, cur.gate, cur.ready, cur.busy, cur.wrap);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.s !== cur) begin
                        failures++;
                        $display("FAIL event cyc=%0d exp_cyc=%0d got phase=%0d set=%h gate=%b ready=%b busy=%b wrap=%b exp phase=%0d set=%h gate=%b ready=%b busy=%b wrap=%b",
                                 cyc, e.cyc, cur.phase, cur.set, cur.gate, cur.ready, cur.busy, cur.wrap,
                                 e.s.phase, e.s.set, e.s.gate, e.s.ready, e.s.busy, e.s.wrap);
                    end else begin
                        $display("event cyc=%0d phase=%0d set=%h gate=%b ready=%b busy=%b wrap=%b ok",
                                 cyc, cur.phase, cur.set, cur.gate, cur.ready, cur.busy, cur.wrap);
                    end
                end
            end
        end
        prev = cur;
        if (done && !reported) begin
            reported = 1;
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL missing_events got_pending=%0d exp_pending=0 next_exp_cyc=%0d",
                         exp_q.size(), exp_q[0].cyc);
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        done = 0;
        RESET_N         = 1'b0;
        bus.CFG_VALID   = 1'b0;
        bus.CFG_PHASE   = '0;
        bus.CFG_DUTY    = '0;
        bus.SWEEP_EN    = 1'b0;
        bus.SWEEP_STEP  = '0;
        bus.SWEEP_DWELL = '0;

        // Reset: guard frame for cycles 1..32, RUN from 33.
        exp_ev(1,  0, 0, 1, 0, 0);
        exp_ev(33, 0, 0, 0, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        RESET_N = 1'b1;

        // Host request at fcnt=10 (cycle 54): applied at 65, gate through 96.
        exp_ev(55, 0, 0, 0, 0, 0);
        exp_ev(65, 7, 3, 1, 0, 0);
        exp_ev(97, 7, 3, 0, 1, 0);
        req_at(54, 5'd7, 4'd3);

        // Request at 98, then a request held through GUARD until first RUN cycle 161.
        exp_ev(99,  7, 3, 0, 0, 0);
        exp_ev(129, 2, 1, 1, 0, 0);
        exp_ev(161, 2, 1, 0, 1, 0);
        exp_ev(162, 2, 1, 0, 0, 0);
        exp_ev(193, 9, 5, 1, 0, 0);
        exp_ev(225, 9, 5, 0, 1, 0);
        req_at(98, 5'd2, 4'd1);
        goto(130);
        bus.CFG_VALID = 1'b1;
        bus.CFG_PHASE = 5'd9;
        bus.CFG_DUTY  = 4'd5;
        goto(162);
        bus.CFG_VALID = 1'b0;

        // Return to phase 0 / duty 0 before the sweep.
        exp_ev(227, 9, 5, 0, 0, 0);
        exp_ev(257, 0, 0, 1, 0, 0);
        exp_ev(289, 0, 0, 0, 1, 0);
        req_at(226, 5'd0, 4'd0);

        // Sweep step 8, dwell 2: 8, 16, 24, 0 with a wrap pulse on the last step.
        exp_ev(353, 0,  0, 0, 0, 0);
        exp_ev(385, 8,  0, 1, 0, 0);
        exp_ev(417, 8,  0, 0, 1, 0);
        exp_ev(481, 8,  0, 0, 0, 0);
        exp_ev(513, 16, 0, 1, 0, 0);
        exp_ev(545, 16, 0, 0, 1, 0);
        exp_ev(609, 16, 0, 0, 0, 0);
        exp_ev(641, 24, 0, 1, 0, 0);
        exp_ev(673, 24, 0, 0, 1, 0);
        exp_ev(737, 24, 0, 0, 0, 1);
        exp_ev(738, 24, 0, 0, 0, 0);
        exp_ev(769, 0,  0, 1, 0, 0);
        exp_ev(801, 0,  0, 0, 1, 0);
        goto(289);
        bus.SWEEP_EN    = 1'b1;
        bus.SWEEP_STEP  = 5'd8;
        bus.SWEEP_DWELL = 8'd2;
        goto(740);
        bus.SWEEP_EN = 1'b0;

        // Sweep trigger at 864 collides with host phase 5: host wins, dwell restarts.
        exp_ev(865,  0,  0, 0, 0, 0);
        exp_ev(897,  5,  0, 1, 0, 0);
        exp_ev(929,  5,  0, 0, 1, 0);
        exp_ev(993,  5,  0, 0, 0, 0);
        exp_ev(1025, 13, 0, 1, 0, 0);
        exp_ev(1057, 13, 0, 0, 1, 0);
        goto(801);
        bus.SWEEP_EN = 1'b1;
        req_at(864, 5'd5, 4'd0);
        goto(994);
        bus.SWEEP_EN = 1'b0;

        // Reset while phase 12 is pending: defaults return, 12 never appears.
        exp_ev(1059, 13, 0, 0, 0, 0);
        exp_ev(1,    0,  0, 1, 0, 0);
        exp_ev(33,   0,  0, 0, 1, 0);
        req_at(1058, 5'd12, 4'd2);
        goto(1070);
        RESET_N = 1'b0;
        @(posedge clk);
        #1;
        RESET_N = 1'b1;
        goto(45);
        done = 1;
    end

endmodule
